// File: rtl/systolic_ctrl.sv
// Tile sequencer for the output-stationary SWAR PE array: clear, skewed feed,
// flush of the skew pipeline, then a back-pressured drain of the bottom row.
module systolic_ctrl #(
   parameter int ARRAY_N = 8,
   parameter int K_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [K_WIDTH-1:0]         k_len,
   input  logic [1:0]                 precision_mode_in,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 precision_mode,
   output logic                       acc_clear,
   output logic                       compute_enable,
   output logic                       drain_enable,
   output logic                       feed_valid,
   output logic [K_WIDTH-1:0]         feed_idx,
   output logic                       last_in,
   output logic                       drain_valid,
   output logic [$clog2(ARRAY_N)-1:0] drain_row
);

   localparam int RW = $clog2(ARRAY_N);
   localparam int CW = K_WIDTH + 1;
   localparam logic [CW-1:0] FLUSH_LEN = CW'(2 * ARRAY_N - 1);
   localparam logic [RW-1:0] TOP_ROW   = RW'(ARRAY_N - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_FEED  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   state_t             state_r;
   logic [K_WIDTH-1:0] k_len_r;
   logic [CW-1:0]      flush_cnt_r;
   logic               in_drain_r;

   // A drain beat happens in the same cycle the writer is ready, so the beat
   // strobes follow out_ready directly while the drain phase flag is registered.
   assign drain_enable = in_drain_r & out_ready;
   assign drain_valid  = in_drain_r & out_ready;

   // Sequencer state and registered array controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         k_len_r        <= {K_WIDTH{1'b0}};
         flush_cnt_r    <= {CW{1'b0}};
         in_drain_r     <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         precision_mode <= 2'b00;
         acc_clear      <= 1'b0;
         compute_enable <= 1'b0;
         feed_valid     <= 1'b0;
         feed_idx       <= {K_WIDTH{1'b0}};
         last_in        <= 1'b0;
         drain_row      <= {RW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r        <= ST_CLEAR;
                  k_len_r        <= k_len;
                  precision_mode <= precision_mode_in;
                  busy           <= 1'b1;
                  acc_clear      <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               acc_clear <= 1'b0;
               if (k_len_r != {K_WIDTH{1'b0}}) begin
                  state_r        <= ST_FEED;
                  feed_valid     <= 1'b1;
                  compute_enable <= 1'b1;
                  feed_idx       <= {K_WIDTH{1'b0}};
                  last_in        <= (k_len_r == K_WIDTH'(1));
               end else begin
                  // Empty tile: skip straight to draining the cleared accumulators.
                  state_r    <= ST_DRAIN;
                  in_drain_r <= 1'b1;
                  drain_row  <= TOP_ROW;
               end
            end
            ST_FEED: begin
               if (last_in) begin
                  state_r     <= ST_FLUSH;
                  feed_valid  <= 1'b0;
                  last_in     <= 1'b0;
                  flush_cnt_r <= CW'(1);
               end else begin
                  feed_idx <= feed_idx + K_WIDTH'(1);
                  last_in  <= ((feed_idx + K_WIDTH'(1)) == (k_len_r - K_WIDTH'(1)));
               end
            end
            ST_FLUSH: begin
               if (flush_cnt_r == FLUSH_LEN) begin
                  state_r        <= ST_DRAIN;
                  compute_enable <= 1'b0;
                  in_drain_r     <= 1'b1;
                  drain_row      <= TOP_ROW;
               end else begin
                  flush_cnt_r <= flush_cnt_r + CW'(1);
               end
            end
            ST_DRAIN: begin
               if (out_ready) begin
                  if (drain_row == {RW{1'b0}}) begin
                     state_r    <= ST_DONE;
                     in_drain_r <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     drain_row <= drain_row - RW'(1);
                  end
               end else begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DONE: begin
               state_r  <= ST_IDLE;
               done     <= 1'b0;
               busy     <= 1'b0;
               feed_idx <= {K_WIDTH{1'b0}};
            end
            default: begin
               state_r        <= ST_IDLE;
               in_drain_r     <= 1'b0;
               busy           <= 1'b0;
               done           <= 1'b0;
               acc_clear      <= 1'b0;
               compute_enable <= 1'b0;
               feed_valid     <= 1'b0;
               last_in        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/systolic_ctrl.md
Name: systolic_ctrl

Overview:
- Sequencer for the ARRAY_N x ARRAY_N output-stationary SWAR PE array.
- Takes one tile command (k_len, precision) and drives the array-wide acc_clear, compute_enable and drain_enable controls.
- Drives the last-vector marker and fetch strobes for the skewed input/weight feeders.
- Paces the drain of accumulators out of the bottom row under back-pressure from the output writer.

Parameters:
- ARRAY_N, 8, rows = columns of the PE array (>=2).
- K_WIDTH, 16, width of k_len and feed_idx.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  tile command strobe; sampled only in IDLE.
- k_len  in  K_WIDTH  packed input vectors per tile; latched on accepted start.
- precision_mode_in  in  2  precision_mode_t for the tile; latched on accepted start.
- out_ready  in  1  output writer can accept a drained row this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at tile completion.
- precision_mode  out  2  latched precision to all PEs.
- acc_clear  out  1  clear all accumulators.
- compute_enable  out  1  array-wide accumulate enable.
- drain_enable  out  1  array-wide vertical shift of accumulators.
- feed_valid  out  1  feeders present vector feed_idx at array edge this cycle.
- feed_idx  out  K_WIDTH  vector index, 0..k_len-1.
- last_in  out  1  marker for the final vector, into column-0 PEs.
- drain_valid  out  1  bottom-row data_to_bottom is a valid result row.
- drain_row  out  $clog2(ARRAY_N)  original array row index of the current drain beat.

Behaviour:
- Reset values: all outputs 0; state IDLE; precision_mode 2'b00.
- Reset is asynchronous at any point, including mid-FEED and mid-DRAIN. It aborts the tile immediately, with no done pulse.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - All controls are low.
  - start=1 latches k_len and precision_mode_in, then goes to CLEAR.
  - start is ignored in all other states.
- CLEAR:
  - acc_clear=1 for exactly 1 cycle.
  - Next state is FEED if k_len!=0, otherwise DRAIN (k_len=0 drains all-zero results).
- FEED:
  - feed_valid=1 and compute_enable=1 for k_len cycles; feed_idx increments 0..k_len-1.
  - last_in=1 only in the cycle where feed_idx==k_len-1.
  - Then goes to FLUSH.
- FLUSH:
  - compute_enable=1 and feed_valid=0 for exactly 2*ARRAY_N-1 cycles.
  - Total compute_enable high time is k_len+2*ARRAY_N-1 cycles, covering skew plus the one-cycle input/weight latch to PE(N-1,N-1).
  - Feeders drive zero while feed_valid=0, so extra cycles add 0.
  - Then goes to DRAIN.
- DRAIN:
  - drain_enable = drain_valid = out_ready. A beat occurs only when out_ready=1; with out_ready=0 the array holds.
  - drain_row starts at ARRAY_N-1 and decrements once per accepted beat.
  - After the ARRAY_N-th accepted beat, goes to DONE.
  - compute_enable=0 throughout.
- DONE: done=1 for 1 cycle, busy=1, then IDLE.
- precision_mode is held constant from CLEAR through DONE and keeps its last value in IDLE.
- Counter width: K_WIDTH+1 so FLUSH and max k_len never wrap. k_len = 2^K_WIDTH-1 is legal.
- acc_clear, compute_enable and drain_enable are mutually exclusive in every cycle.
- Start-to-done latency, with out_ready held 1: 1+k_len+(2*ARRAY_N-1)+ARRAY_N+1 cycles after the start cycle.

Test Plan:
- ARRAY_N=4, start with k_len=3, out_ready=1:
  - acc_clear 1 cycle; feed_idx 0,1,2 with last_in on idx 2.
  - compute_enable high 10 cycles, drain_enable 4 cycles with drain_row 3,2,1,0.
  - done pulse 16 cycles after start; end-to-end PE results match golden INT8 dot products.
- Same tile with out_ready toggling 1,0,0,1,0,1,1 during DRAIN:
  - Exactly 4 drain beats, only on out_ready=1 cycles.
  - drain_row changes only on beats; accumulators intact.
- start pulsed during FEED and precision_mode_in changed mid-tile:
  - Second start is ignored; precision_mode output unchanged until next IDLE start.
- k_len=0:
  - CLEAR followed directly by DRAIN; feed_valid and compute_enable never high.
  - 4 beats of zero; done pulse.
- rst_n low in the 2nd FEED cycle:
  - All outputs 0 in the same cycle; busy=0; no done.
  - A subsequent start with k_len=2 completes normally.
- k_len=65535:
  - compute_enable high exactly 65542 cycles; feed_idx ends at 65534 with last_in, no wrap.
